uart_tx_fifo: RTL and testbench

Parametrised successor to the team's single-byte UART transmitter: a buffered serial transmitter with configurable word width, parity mode, stop-bit count and FIFO depth. Firmware-side logic (or a testbench stimulus driver) pushes words through a valid/ready port. The block queues them and serialises them back-to-back, LSB first, on one TX line. It replaces the unbuffered uart_tx wherever more than one byte may be issued before the line is idle, e.g. command/status links of the IAGC top.

---
 rtl/uart_tx_fifo_if.sv | 12 +
 rtl/uart_tx_fifo.sv | 171 +++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// Write-side handshake of the buffered UART transmitter: valid/data in, ready/overflow back.
interface uart_tx_fifo_if #(
    parameter int DATA_BITS = 8
);
    logic                 i_valid;
    logic [DATA_BITS-1:0] i_data;
    logic                 o_ready;
    logic                 o_overflow;

    modport master (output i_valid, output i_data, input o_ready, input o_overflow);
    modport slave  (input i_valid, input i_data, output o_ready, output o_overflow);
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: circular FIFO feeding a start/data/parity/stop serialiser
// that sends queued words back-to-back, LSB first.
module uart_tx_fifo #(
    parameter int CLK_FREQUENCY  = 125000000,
    parameter int UART_FREQUENCY = 9600,
    parameter int DATA_BITS      = 8,
    parameter int PARITY         = 0,
    parameter int STOP_BITS      = 1,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    uart_tx_fifo_if.slave               bus,
    output logic                        o_tx,
    output logic                        o_busy,
    output logic [$clog2(FIFO_DEPTH):0] o_fifo_count
);

    localparam int DIV = CLK_FREQUENCY / UART_FREQUENCY;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(DIV);
    localparam int BW  = $clog2(DATA_BITS);

    localparam logic [AW:0]   FULL      = (AW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    localparam logic          ODD       = (PARITY == 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        baud_q, baud_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 active_q, active_d;
    logic                 ovf_q, ovf_d;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [AW:0]          count_q, count_d;

    logic                 push;
    logic                 pop;
    logic                 baud_last;
    logic [DATA_BITS-1:0] head;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];

    assign head      = mem[rd_ptr_q];
    assign baud_last = (baud_q == BAUD_LAST);

    // Full blocks the write even when a pop lands on the same edge.
    assign push = bus.i_valid && (count_q != FULL) && !i_reset;

    always_ff @(posedge i_clock) begin
        if (push) begin
            mem[wr_ptr_q] <= bus.i_data;
        end
    end

    always_comb begin
        state_d  = state_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        par_d    = par_q;
        pop      = 1'b0;
        baud_d   = (state_q == S_IDLE || baud_last) ? '0 : baud_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = head;
                    par_d   = (^head) ^ ODD;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_last) begin
                    bit_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (baud_last) begin
                    bit_d   = '0;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (baud_last) begin
                    if (bit_q != STOP_LAST) begin
                        bit_d = bit_q + 1'b1;
                    end else if (count_q != '0) begin
                        // Chain straight into the next start bit, no idle cycle.
                        pop     = 1'b1;
                        shift_d = head;
                        par_d   = (^head) ^ ODD;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        case (state_q)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_q[0];
            S_PARITY: tx_d = par_q;
            default:  tx_d = 1'b1;
        endcase
        // active_q tracks the line, which trails the state by one cycle.
        active_d = (state_q != S_IDLE);
        ovf_d    = bus.i_valid && (count_q == FULL);
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            tx_q     <= 1'b1;
            active_q <= 1'b0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            tx_q     <= tx_d;
            active_q <= active_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign o_tx           = tx_q;
    assign o_busy         = (state_q != S_IDLE) || (count_q != '0) || active_q;
    assign o_fifo_count   = count_q;
    assign bus.o_ready    = (count_q != FULL);
    assign bus.o_overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three configurations (8N1, 8E2, 7O1, depth 4, DIV=10) checked
// against a frame-schedule model and against hand-derived constants.
module tb_uart_tx_fifo;

    localparam int N     = 8000;
    localparam int DIV   = 10;
    localparam int DEPTH = 4;
    localparam int DB_P  [3] = '{8, 8, 7};
    localparam int PAR_P [3] = '{0, 2, 1};
    localparam int SB_P  [3] = '{1, 2, 1};
    localparam int L_SPEC[3] = '{100, 120, 100};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] vld = 3'b000;
    logic [8:0] dat [3];

    logic [2:0] tx_w, rdy_w, ovf_w, busy_w;
    logic [2:0] cnt_w [3];

    always #5 clk = ~clk;

    genvar gi;
    for (gi = 0; gi < 3; gi++) begin : g_dut
        localparam int DB = DB_P[gi];
        uart_tx_fifo_if #(.DATA_BITS(DB)) bus ();
        assign bus.i_valid = vld[gi];
        assign bus.i_data  = dat[gi][DB-1:0];
        assign rdy_w[gi]   = bus.o_ready;
        assign ovf_w[gi]   = bus.o_overflow;
        uart_tx_fifo #(
            .CLK_FREQUENCY (1000),
            .UART_FREQUENCY(100),
            .DATA_BITS     (DB),
            .PARITY        (PAR_P[gi]),
            .STOP_BITS     (SB_P[gi]),
            .FIFO_DEPTH    (DEPTH)
        ) u_dut (
            .i_clock     (clk),
            .i_reset     (rst),
            .bus         (bus),
            .o_tx        (tx_w[gi]),
            .o_busy      (busy_w[gi]),
            .o_fifo_count(cnt_w[gi])
        );
    end

    // Model state and recorded traces (index = edge number).
    int       cyc = 0;
    int       total = 0;
    int       bad = 0;
    int       trace_start = 2;
    int       cnt_m  [3];
    int       last_f [3];
    bit       pop_at [3][N];
    bit [2:0] exp_tx [N];
    bit [2:0] exp_rdy[N];
    bit [2:0] exp_ovf[N];
    bit [2:0] exp_busy[N];
    int       exp_cnt[3][N];
    logic [2:0] obs_tx [N];
    logic [2:0] obs_rdy[N];
    logic [2:0] obs_ovf[N];
    logic [2:0] obs_busy[N];
    logic [2:0] obs_cnt[3][N];

    function automatic int frame_len(int d);
        return (1 + DB_P[d] + ((PAR_P[d] != 0) ? 1 : 0) + SB_P[d]) * DIV;
    endfunction

    // Line level i cycles into a frame carrying word w.
    function automatic bit frame_bit(int d, logic [8:0] w, int i);
        int j;
        int ones;
        j = i / DIV;
        ones = 0;
        for (int b = 0; b < DB_P[d]; b++) ones += int'(w[b]);
        if (j == 0) return 1'b0;
        if (j <= DB_P[d]) return w[j-1];
        if (PAR_P[d] != 0 && j == DB_P[d] + 1)
            return (PAR_P[d] == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
        return 1'b1;
    endfunction

    // Advance one clock: update the model for the coming edge, then record DUT outputs.
    task automatic tick();
        int e;
        e = cyc + 1;
        if (e >= N - 1) begin
            $display("FAIL trace_overrun got=%0d want<%0d", e, N - 1);
            $fatal(1);
        end
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                cnt_m[d]  = 0;
                last_f[d] = -1000;
                for (int t = e; t < N; t++) begin
                    exp_tx[t][d] = 1'b1;
                    pop_at[d][t] = 1'b0;
                end
                exp_rdy[e][d]  = 1'b1;
                exp_ovf[e][d]  = 1'b0;
                exp_busy[e][d] = 1'b0;
                exp_cnt[d][e]  = 0;
            end else begin
                int  len;
                int  f;
                bit  r;
                bit  acc;
                len = frame_len(d);
                r   = (cnt_m[d] < DEPTH);
                acc = vld[d] && r;
                exp_rdy[e][d] = r;
                exp_ovf[e][d] = vld[d] && !r;
                if (acc) begin
                    f = (e + 2 > last_f[d] + len) ? e + 2 : last_f[d] + len;
                    pop_at[d][f-1] = 1'b1;
                    for (int i = 0; i < len; i++)
                        if (f + i < N) exp_tx[f+i][d] = frame_bit(d, dat[d], i);
                    last_f[d] = f;
                    $display("accept dut=%0d edge=%0d data=%h frame_at=%0d", d, e, dat[d], f);
                end
                cnt_m[d] = cnt_m[d] + (acc ? 1 : 0) - (pop_at[d][e] ? 1 : 0);
                exp_cnt[d][e]  = cnt_m[d];
                exp_busy[e][d] = (cnt_m[d] > 0) || (e < last_f[d] + len);
            end
        end
        obs_rdy[e] = rdy_w;
        @(posedge clk);
        cyc = e;
        @(negedge clk);
        obs_tx[e]   = tx_w;
        obs_ovf[e]  = ovf_w;
        obs_busy[e] = busy_w;
        for (int d = 0; d < 3; d++) obs_cnt[d][e] = cnt_w[d];
    endtask

    task automatic test_reset();
        rst = 1'b1;
        vld = 3'b111;
        for (int d = 0; d < 3; d++) dat[d] = 9'($urandom);
        tick(); tick(); tick();
        for (int d = 0; d < 3; d++) begin
            total += 5;
            if (tx_w[d] !== 1'b1) begin bad++; $display("FAIL reset_tx dut=%0d got=%b want=1", d, tx_w[d]); end
            if (rdy_w[d] !== 1'b1) begin bad++; $display("FAIL reset_ready dut=%0d got=%b want=1", d, rdy_w[d]); end
            if (ovf_w[d] !== 1'b0) begin bad++; $display("FAIL reset_ovf dut=%0d got=%b want=0", d, ovf_w[d]); end
            if (busy_w[d] !== 1'b0) begin bad++; $display("FAIL reset_busy dut=%0d got=%b want=0", d, busy_w[d]); end
            if (cnt_w[d] !== 3'd0) begin bad++; $display("FAIL reset_count dut=%0d got=%0d want=0", d, cnt_w[d]); end
        end
        rst = 1'b0;
        vld = 3'b000;
        tick(); tick();
        trace_start = 2;
    endtask

    task automatic test_single_frame();
        int k;
        int sd [6];
        int so [6];
        bit sv [6];
        sd = '{0, 0, 1, 1, 2, 2};
        so = '{80, 70, 90, 105, 70, 80};
        sv = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        dat[0] = 9'h080; dat[1] = 9'h080; dat[2] = 9'h07F;
        vld = 3'b111;
        tick();
        k = cyc;
        vld = 3'b000;
        repeat (130) tick();
        for (int d = 0; d < 3; d++) begin
            int L;
            L = L_SPEC[d];
            total += 8;
            if (obs_cnt[d][k] !== 3'd1) begin bad++; $display("FAIL single_count_k dut=%0d got=%0d want=1", d, obs_cnt[d][k]); end
            if (obs_cnt[d][k+1] !== 3'd0) begin bad++; $display("FAIL single_count_pop dut=%0d got=%0d want=0", d, obs_cnt[d][k+1]); end
            if (obs_tx[k+1][d] !== 1'b1) begin bad++; $display("FAIL single_tx_k1 dut=%0d got=%b want=1", d, obs_tx[k+1][d]); end
            if (obs_tx[k+2][d] !== 1'b0) begin bad++; $display("FAIL single_start dut=%0d got=%b want=0", d, obs_tx[k+2][d]); end
            if (obs_tx[k+1+L][d] !== 1'b1) begin bad++; $display("FAIL single_last_stop dut=%0d got=%b want=1", d, obs_tx[k+1+L][d]); end
            if (obs_tx[k+2+L][d] !== 1'b1) begin bad++; $display("FAIL single_idle_after dut=%0d got=%b want=1", d, obs_tx[k+2+L][d]); end
            if (obs_busy[k+1+L][d] !== 1'b1) begin bad++; $display("FAIL single_busy_end dut=%0d got=%b want=1", d, obs_busy[k+1+L][d]); end
            if (obs_busy[k+2+L][d] !== 1'b0) begin bad++; $display("FAIL single_busy_fall dut=%0d got=%b want=0", d, obs_busy[k+2+L][d]); end
        end
        for (int i = 0; i < 6; i++) begin
            total++;
            if (obs_tx[k+2+so[i]+5][sd[i]] !== sv[i]) begin
                bad++;
                $display("FAIL single_slot dut=%0d offset=%0d got=%b want=%b", sd[i], so[i], obs_tx[k+2+so[i]+5][sd[i]], sv[i]);
            end
        end
    endtask

    task automatic test_overflow();
        int s;
        s = cyc + 1;
        for (int i = 0; i < 6; i++) begin
            for (int d = 0; d < 3; d++) dat[d] = 9'($urandom);
            vld = 3'b111;
            tick();
        end
        vld = 3'b000;
        tick();
        for (int d = 0; d < 3; d++) begin
            total += 6;
            if (obs_rdy[s+4][d] !== 1'b1) begin bad++; $display("FAIL ovf_ready5 dut=%0d got=%b want=1", d, obs_rdy[s+4][d]); end
            if (obs_rdy[s+5][d] !== 1'b0) begin bad++; $display("FAIL ovf_ready6 dut=%0d got=%b want=0", d, obs_rdy[s+5][d]); end
            if (obs_ovf[s+4][d] !== 1'b0) begin bad++; $display("FAIL ovf_early dut=%0d got=%b want=0", d, obs_ovf[s+4][d]); end
            if (obs_ovf[s+5][d] !== 1'b1) begin bad++; $display("FAIL ovf_pulse dut=%0d got=%b want=1", d, obs_ovf[s+5][d]); end
            if (obs_ovf[s+6][d] !== 1'b0) begin bad++; $display("FAIL ovf_width dut=%0d got=%b want=0", d, obs_ovf[s+6][d]); end
            if (obs_cnt[d][s+4] !== 3'd4) begin bad++; $display("FAIL ovf_count_full dut=%0d got=%0d want=4", d, obs_cnt[d][s+4]); end
        end
        repeat (620) tick();
        for (int d = 0; d < 3; d++) begin
            int L;
            L = L_SPEC[d];
            for (int j = 0; j < 5; j++) begin
                total++;
                if (obs_tx[s+2+j*L][d] !== 1'b0) begin
                    bad++;
                    $display("FAIL ovf_contig_start dut=%0d frame=%0d got=%b want=0", d, j, obs_tx[s+2+j*L][d]);
                end
            end
            total += 2;
            if (obs_busy[s+1+5*L][d] !== 1'b1) begin bad++; $display("FAIL ovf_busy_end dut=%0d got=%b want=1", d, obs_busy[s+1+5*L][d]); end
            if (obs_busy[s+2+5*L][d] !== 1'b0) begin bad++; $display("FAIL ovf_busy_fall dut=%0d got=%b want=0", d, obs_busy[s+2+5*L][d]); end
        end
    endtask

    task automatic test_last_stop();
        int k;
        k = cyc + 1;
        for (int d = 0; d < 3; d++) dat[d] = 9'($urandom);
        vld = 3'b111;
        tick();
        vld = 3'b000;
        while (cyc < k + 140) begin
            for (int d = 0; d < 3; d++) begin
                vld[d] = (cyc + 1 == k + 1 + L_SPEC[d]);
                if (vld[d]) dat[d] = 9'h055;
            end
            tick();
        end
        vld = 3'b000;
        repeat (140) tick();
        for (int d = 0; d < 3; d++) begin
            int L;
            L = L_SPEC[d];
            total += 5;
            if (obs_tx[k+1+L][d] !== 1'b1) begin bad++; $display("FAIL last_stop_level dut=%0d got=%b want=1", d, obs_tx[k+1+L][d]); end
            if (obs_cnt[d][k+1+L] !== 3'd1) begin bad++; $display("FAIL last_stop_accept dut=%0d got=%0d want=1", d, obs_cnt[d][k+1+L]); end
            if (obs_tx[k+2+L][d] !== 1'b1) begin bad++; $display("FAIL last_stop_gap dut=%0d got=%b want=1", d, obs_tx[k+2+L][d]); end
            if (obs_busy[k+2+L][d] !== 1'b1) begin bad++; $display("FAIL last_stop_busy dut=%0d got=%b want=1", d, obs_busy[k+2+L][d]); end
            if (obs_tx[k+3+L][d] !== 1'b0) begin bad++; $display("FAIL last_stop_start dut=%0d got=%b want=0", d, obs_tx[k+3+L][d]); end
        end
    endtask

    task automatic test_reset_mid();
        int r0;
        for (int i = 0; i < 4; i++) begin
            for (int d = 0; d < 3; d++) dat[d] = 9'($urandom);
            vld = 3'b111;
            tick();
        end
        vld = 3'b000;
        repeat (35) tick();
        for (int d = 0; d < 3; d++) begin
            total++;
            if (obs_cnt[d][cyc] !== 3'd3) begin bad++; $display("FAIL mid_queued dut=%0d got=%0d want=3", d, obs_cnt[d][cyc]); end
        end
        #2 rst = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            total += 2;
            if (tx_w[d] !== 1'b1) begin bad++; $display("FAIL mid_reset_tx dut=%0d got=%b want=1", d, tx_w[d]); end
            if (cnt_w[d] !== 3'd0) begin bad++; $display("FAIL mid_reset_count dut=%0d got=%0d want=0", d, cnt_w[d]); end
        end
        tick(); tick();
        rst = 1'b0;
        r0 = cyc;
        repeat (150) tick();
        for (int t = r0 + 1; t <= cyc; t++) begin
            for (int d = 0; d < 3; d++) begin
                total += 2;
                if (obs_tx[t][d] !== 1'b1) begin bad++; $display("FAIL mid_after_tx dut=%0d edge=%0d got=%b want=1", d, t, obs_tx[t][d]); end
                if (obs_busy[t][d] !== 1'b0) begin bad++; $display("FAIL mid_after_busy dut=%0d edge=%0d got=%b want=0", d, t, obs_busy[t][d]); end
            end
        end
    endtask

    task automatic test_random();
        int pct;
        for (int i = 0; i < 3000; i++) begin
            pct = (i < 1000) ? 1 : ((i < 2000) ? 5 : 60);
            for (int d = 0; d < 3; d++) begin
                vld[d] = ($urandom_range(0, 99) < pct);
                dat[d] = 9'($urandom);
            end
            tick();
        end
        vld = 3'b000;
        repeat (700) tick();
    endtask

    task automatic test_model_trace();
        for (int t = trace_start; t <= cyc; t++) begin
            for (int d = 0; d < 3; d++) begin
                total += 5;
                if (obs_tx[t][d] !== exp_tx[t][d]) begin bad++; $display("FAIL trace_tx dut=%0d edge=%0d got=%b want=%b", d, t, obs_tx[t][d], exp_tx[t][d]); end
                if (obs_rdy[t][d] !== exp_rdy[t][d]) begin bad++; $display("FAIL trace_ready dut=%0d edge=%0d got=%b want=%b", d, t, obs_rdy[t][d], exp_rdy[t][d]); end
                if (obs_ovf[t][d] !== exp_ovf[t][d]) begin bad++; $display("FAIL trace_ovf dut=%0d edge=%0d got=%b want=%b", d, t, obs_ovf[t][d], exp_ovf[t][d]); end
                if (obs_busy[t][d] !== exp_busy[t][d]) begin bad++; $display("FAIL trace_busy dut=%0d edge=%0d got=%b want=%b", d, t, obs_busy[t][d], exp_busy[t][d]); end
                if (obs_cnt[d][t] !== 3'(exp_cnt[d][t])) begin bad++; $display("FAIL trace_count dut=%0d edge=%0d got=%0d want=%0d", d, t, obs_cnt[d][t], exp_cnt[d][t]); end
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            dat[d]    = 9'h000;
            cnt_m[d]  = 0;
            last_f[d] = -1000;
        end
        for (int t = 0; t < N; t++) exp_tx[t] = 3'b111;
        test_reset();
        test_single_frame();
        test_overflow();
        test_last_stop();
        test_reset_mid();
        test_random();
        test_model_trace();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
